eth_tx_framer: RTL and testbench

//  Byte-stream MAC transmit framer between the header/payload generators and rgmii_tx.

---
 rtl/eth_tx_framer.sv | 222 ++++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// MAC transmit framer: wraps a valid/ready body stream with preamble, SFD, zero pad and
// CRC-32 FCS, then holds off the next frame for the inter-frame gap.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle; waits for s_valid to open a frame
// ST_PRE   | preamble byte (0x55) on tx_data
// ST_SFD   | SFD (0xD5) on tx_data; s_ready high, first body byte taken
// ST_BODY  | body byte on tx_data; s_ready high until s_last accepted
// ST_PAD   | last body / pad byte on tx_data; emitting 0x00 to MIN_FRAME
// ST_FCS   | emitting the four FCS bytes, LSB byte first
// ST_IFG   | line idle for the inter-frame gap

module eth_tx_framer #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int IFG_BYTES    = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_BODY,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } state_t;

   localparam logic [7:0]  PRE_BYTE   = 8'h55;
   localparam logic [7:0]  SFD_BYTE   = 8'hD5;
   localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
   localparam logic [11:0] MIN_LEN    = 12'(MIN_FRAME);
   localparam logic [15:0] PRE_RELOAD = 16'(PREAMBLE_LEN > 0 ? PREAMBLE_LEN - 1 : 0);
   localparam logic [15:0] IFG_RELOAD = 16'(IFG_BYTES > 0 ? IFG_BYTES - 1 : 0);
   // the abort cycle itself is already the first idle cycle of the gap
   localparam logic [15:0] ABT_RELOAD = 16'(IFG_BYTES > 1 ? IFG_BYTES - 2 : 0);
   localparam logic [15:0] FCS_RELOAD = 16'd3;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        s_ready_q, s_ready_d;
   logic        busy_q, busy_d;
   logic        underrun_q, underrun_d;
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [15:0] tmr_q, tmr_d;
   logic [31:0] crc_q, crc_d;

   logic [10:0] byte_cnt_inc;
   logic [11:0] cnt_plus1;
   logic [31:0] fcs;
   logic [1:0]  fcs_idx;
   logic [7:0]  fcs_byte;

   assign byte_cnt_inc = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 11'd1;
   assign cnt_plus1    = {1'b0, byte_cnt_q} + 12'd1;
   assign fcs          = ~crc_q;
   assign fcs_idx      = 2'd3 - tmr_q[1:0];
   assign fcs_byte     = fcs[{fcs_idx, 3'b000} +: 8];

   always_comb begin
      state_d    = state_q;
      tx_data_d  = 8'h00;
      tx_valid_d = 1'b0;
      s_ready_d  = 1'b0;
      underrun_d = 1'b0;
      byte_cnt_d = byte_cnt_q;
      tmr_d      = tmr_q;
      crc_d      = crc_q;

      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               crc_d      = CRC_INIT;
               byte_cnt_d = '0;
               tx_valid_d = 1'b1;
               if (PREAMBLE_LEN == 0) begin
                  tx_data_d = SFD_BYTE;
                  s_ready_d = 1'b1;
                  state_d   = ST_SFD;
               end else begin
                  tx_data_d = PRE_BYTE;
                  tmr_d     = PRE_RELOAD;
                  state_d   = ST_PRE;
               end
            end
         end

         ST_PRE: begin
            tx_valid_d = 1'b1;
            if (tmr_q == '0) begin
               tx_data_d = SFD_BYTE;
               s_ready_d = 1'b1;
               state_d   = ST_SFD;
            end else begin
               tx_data_d = PRE_BYTE;
               tmr_d     = tmr_q - 16'd1;
            end
         end

         ST_SFD, ST_BODY: begin
            if (s_valid) begin
               tx_valid_d = 1'b1;
               tx_data_d  = s_data;
               crc_d      = crc_byte(crc_q, s_data);
               byte_cnt_d = byte_cnt_inc;
               if (s_last) begin
                  if (cnt_plus1 < MIN_LEN) begin
                     state_d = ST_PAD;
                  end else begin
                     tmr_d   = FCS_RELOAD;
                     state_d = ST_FCS;
                  end
               end else begin
                  s_ready_d = 1'b1;
                  state_d   = ST_BODY;
               end
            end else begin
               // upstream starved mid-frame: the frame cannot be completed on the wire
               underrun_d = 1'b1;
               if (IFG_BYTES > 1) begin
                  tmr_d   = ABT_RELOAD;
                  state_d = ST_IFG;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_PAD: begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h00;
            crc_d      = crc_byte(crc_q, 8'h00);
            byte_cnt_d = byte_cnt_inc;
            if (cnt_plus1 >= MIN_LEN) begin
               tmr_d   = FCS_RELOAD;
               state_d = ST_FCS;
            end
         end

         ST_FCS: begin
            tx_valid_d = 1'b1;
            tx_data_d  = fcs_byte;
            if (tmr_q == '0) begin
               if (IFG_BYTES > 0) begin
                  tmr_d   = IFG_RELOAD;
                  state_d = ST_IFG;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end

         ST_IFG: begin
            if (tmr_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
         byte_cnt_q <= '0;
         tmr_q      <= '0;
         crc_q      <= CRC_INIT;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
         byte_cnt_q <= byte_cnt_d;
         tmr_q      <= tmr_d;
         crc_q      <= crc_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: stimulus queues expected wire bytes, run lengths and
// gaps; negedge monitors pop and compare whenever the framer drives the line.

module tb_eth_tx_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_data, z_s_data;
   logic       s_valid, z_s_valid;
   logic       s_last, z_s_last;
   logic       s_ready, z_s_ready;
   logic [7:0] tx_data, z_tx_data;
   logic       tx_valid, z_tx_valid;
   logic       busy, z_busy;
   logic       underrun, z_underrun;

   always #4 clk = ~clk;

   eth_tx_framer dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
      .underrun(underrun)
   );

   eth_tx_framer #(.MIN_FRAME(0)) dut_nopad (
      .clk(clk), .rst(rst), .s_data(z_s_data), .s_valid(z_s_valid), .s_last(z_s_last),
      .s_ready(z_s_ready), .tx_data(z_tx_data), .tx_valid(z_tx_valid), .busy(z_busy),
      .underrun(z_underrun)
   );

   localparam logic [31:0] NIB [16] = '{
      32'h00000000, 32'h1DB71064, 32'h3B6E20C8, 32'h26D930AC,
      32'h76DC4190, 32'h6B6B51F4, 32'h4DB26158, 32'h5005713C,
      32'hEDB88320, 32'hF00F9344, 32'hD6D6A3E8, 32'hCB61B38C,
      32'h9B64C2B0, 32'h86D3D2D4, 32'hA00AE278, 32'hBDBDF21C
   };

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   int         exp_run_q[$];
   int         exp_gap_q[$];
   logic [7:0] exp0_q[$];
   int         exp0_run_q[$];
   logic [7:0] body_q[$];
   logic [7:0] fr_q[$];

   int run_len = 0, idle_len = 0, und_cycles = 0;
   bit rdy_in_gap = 0;
   int run0_len = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [31:0] ref_crc();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (fr_q[i]) begin
         c = (c >> 4) ^ NIB[c[3:0] ^ fr_q[i][3:0]];
         c = (c >> 4) ^ NIB[c[3:0] ^ fr_q[i][7:4]];
      end
      return c;
   endfunction

   // main framer monitor
   always @(negedge clk) begin
      if (rst) begin
         run_len    = 0;
         idle_len   = 0;
         rdy_in_gap = 0;
      end else if (tx_valid) begin
         if (run_len == 0 && exp_gap_q.size() > 0) begin
            chk("ifg_idle_cycles", idle_len, exp_gap_q.pop_front());
            chk("s_ready_in_gap", rdy_in_gap, 0);
         end
         run_len++;
         idle_len   = 0;
         rdy_in_gap = 0;
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_extra_byte: got %0h with nothing expected at %0t", tx_data, $time);
         end else begin
            chk("tx_byte", tx_data, exp_q.pop_front());
         end
      end else begin
         if (run_len > 0) begin
            if (exp_run_q.size() == 0) begin
               total++; bad++;
               $display("FAIL tx_run_extra: got run %0d with nothing expected", run_len);
            end else begin
               chk("tx_valid_run", run_len, exp_run_q.pop_front());
            end
            run_len = 0;
         end
         idle_len++;
         if (s_ready) rdy_in_gap = 1;
         chk("idle_data_zero", tx_data, 0);
      end
      if (!rst && underrun) und_cycles++;
   end

   // no-pad framer monitor
   always @(negedge clk) begin
      if (rst) begin
         run0_len = 0;
      end else if (z_tx_valid) begin
         run0_len++;
         if (exp0_q.size() == 0) begin
            total++; bad++;
            $display("FAIL nopad_extra_byte: got %0h with nothing expected", z_tx_data);
         end else begin
            chk("nopad_tx_byte", z_tx_data, exp0_q.pop_front());
         end
      end else if (run0_len > 0) begin
         if (exp0_run_q.size() == 0) begin
            total++; bad++;
            $display("FAIL nopad_run_extra: got run %0d with nothing expected", run0_len);
         end else begin
            chk("nopad_tx_valid_run", run0_len, exp0_run_q.pop_front());
         end
         run0_len = 0;
      end
   end

   task automatic fill_body(int n);
      body_q.delete();
      for (int i = 0; i < n; i++) body_q.push_back(8'($urandom));
   endtask

   task automatic expect_frame(int n_abort);
      logic [31:0] fcs;
      fr_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      if (n_abort > 0) begin
         for (int i = 0; i < n_abort; i++) exp_q.push_back(body_q[i]);
         exp_run_q.push_back(8 + n_abort);
      end else begin
         foreach (body_q[i]) fr_q.push_back(body_q[i]);
         while (fr_q.size() < 60) fr_q.push_back(8'h00);
         fcs = ~ref_crc();
         foreach (fr_q[i]) exp_q.push_back(fr_q[i]);
         exp_q.push_back(fcs[7:0]);
         exp_q.push_back(fcs[15:8]);
         exp_q.push_back(fcs[23:16]);
         exp_q.push_back(fcs[31:24]);
         exp_run_q.push_back(8 + fr_q.size() + 4);
      end
   endtask

   task automatic put(bit sel, logic [7:0] d, logic v, logic l);
      if (sel) begin
         z_s_data = d; z_s_valid = v; z_s_last = l;
      end else begin
         s_data = d; s_valid = v; s_last = l;
      end
   endtask

   // drives body_q; n_abort > 0 stops after that many bytes without s_last
   task automatic drive_frame(bit sel, int n_abort);
      int  n, guard;
      bit  hs;
      n = (n_abort > 0) ? n_abort : body_q.size();
      for (int i = 0; i < n; i++) begin
         put(sel, body_q[i], 1'b1, (n_abort == 0 && i == n - 1));
         guard = 0;
         hs    = 0;
         while (!hs && guard < 4000) begin
            @(negedge clk);
            hs = sel ? z_s_ready : s_ready;
            @(posedge clk);
            #1;
            guard++;
         end
         if (!hs) begin
            chk("handshake_timeout", hs, 1);
            break;
         end
      end
      put(sel, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() + exp_run_q.size() + exp0_q.size() + exp0_run_q.size()) != 0
             && g < 5000) begin
         @(posedge clk);
         g++;
      end
      if (g >= 5000) chk("drain_timeout", g, 0);
      repeat (16) @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int und0;
      int lens [7];
      rst = 1'b1;
      put(0, 8'h00, 1'b0, 1'b0);
      put(1, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_nopad_tx_valid", z_tx_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1: CRC check vector on the no-pad framer, hand-derived wire bytes
      body_q.delete();
      for (int i = 0; i < 9; i++) body_q.push_back(8'h31 + 8'(i));
      repeat (7) exp0_q.push_back(8'h55);
      exp0_q.push_back(8'hD5);
      foreach (body_q[i]) exp0_q.push_back(body_q[i]);
      exp0_q.push_back(8'h26); exp0_q.push_back(8'h39);
      exp0_q.push_back(8'hF4); exp0_q.push_back(8'hCB);
      exp0_run_q.push_back(21);
      drive_frame(1, 0);
      drain();

      // 2: short body padded to the minimum frame
      body_q.delete();
      for (int i = 0; i < 14; i++) body_q.push_back(8'(i * 7 + 3));
      expect_frame(0);
      drive_frame(0, 0);
      drain();
      chk("busy_after_frame", busy, 0);

      // 3: two 64-byte frames back to back
      fill_body(64);
      expect_frame(0);
      drive_frame(0, 0);
      fill_body(64);
      expect_frame(0);
      exp_gap_q.push_back(12);
      drive_frame(0, 0);
      drain();

      // 4: starve after body byte 20, then a follow-on frame
      und0 = und_cycles;
      fill_body(40);
      expect_frame(20);
      drive_frame(0, 20);
      @(posedge clk);
      #1;
      fill_body(30);
      expect_frame(0);
      exp_gap_q.push_back(12);
      drive_frame(0, 0);
      drain();
      chk("underrun_pulse_cycles", und_cycles - und0, 1);

      // 5: reset while the FCS is on the wire
      und0 = und_cycles;
      fill_body(10);
      expect_frame(0);
      drive_frame(0, 0);
      for (int g = 0; g < 500 && exp_q.size() > 2; g++) begin
         @(posedge clk);
         #1;
      end
      chk("fcs_reached", exp_q.size(), 2);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_tx_data", tx_data, 8'h00);
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_underrun", underrun, 0);
      exp_q.delete();
      exp_run_q.delete();
      rst = 1'b0;
      @(posedge clk);
      #1;
      fill_body(61);
      expect_frame(0);
      drive_frame(0, 0);
      drain();
      chk("no_underrun_on_rst", und_cycles - und0, 0);

      // 6: length sweep across the pad boundary and up to max size
      lens = '{1, 59, 60, 61, 200, 1514, 0};
      lens[6] = int'($urandom_range(2, 120));
      foreach (lens[k]) begin
         fill_body(lens[k]);
         expect_frame(0);
         drive_frame(0, 0);
      end
      drain();
      chk("gap_checks_consumed", exp_gap_q.size(), 0);
      chk("final_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
